// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encoding, type-field width and sink channel FSM states.
package noc_pkg;

  typedef logic [1:0] flit_type_t;

  // The type field occupies the top FLIT_TYPE_W bits of every flit.
  localparam int unsigned FLIT_TYPE_W = 2;

  localparam flit_type_t FLIT_HEAD   = 2'b10;
  localparam flit_type_t FLIT_BODY   = 2'b00;
  localparam flit_type_t FLIT_TAIL   = 2'b01;
  localparam flit_type_t FLIT_SINGLE = 2'b11;

  typedef enum logic {
    StIdle,
    StInPkt
  } ch_state_e;

  typedef enum logic [1:0] {
    ErrNone,
    ErrOrphan,
    ErrRestart,
    ErrOverflow
  } err_kind_e;

endpackage

// File: rtl/sink_channel.sv
// One sink channel: four-phase receiver plus packet framing FSM.
// Framing checks are enabled by defining PACKET_SINK_CHECK_EN.
module sink_channel
  import noc_pkg::*;
#(
  parameter int unsigned ID        = 0,
  parameter int unsigned CH        = 0,
  parameter int unsigned BUFF_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  flit_type_t         ftype,
  output logic               ack,
  output logic               done,
  output logic [BUFF_BITS:0] len,
  output logic               accept,
  output logic               fin,
  output logic               err
);

`ifdef PACKET_SINK_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam logic [BUFF_BITS:0] OneLen = {{BUFF_BITS{1'b0}}, 1'b1};
  localparam logic [BUFF_BITS:0] MaxLen = {1'b1, {BUFF_BITS{1'b0}}};

  ch_state_e          state_q, state_d;
  logic [BUFF_BITS:0] len_q, len_d, len_sat, fin_len, len_out_q;
  logic               ack_q, done_q;
  err_kind_e          kind;

  assign accept  = req & ~ack_q;
  assign len_sat = (len_q == MaxLen) ? MaxLen : len_q + OneLen;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fin     = 1'b0;
    fin_len = '0;
    err     = 1'b0;
    kind    = ErrNone;
    if (accept) begin
      // Head/single always restart framing; in a packet that abandons it.
      if (state_q == StIdle || ftype[1]) begin
        if (state_q == StInPkt) begin
          err  = CheckEn;
          kind = ErrRestart;
        end
        unique case (ftype)
          FLIT_HEAD: begin
            state_d = StInPkt;
            len_d   = OneLen;
          end
          FLIT_SINGLE: begin
            state_d = StIdle;
            len_d   = '0;
            fin     = 1'b1;
            fin_len = OneLen;
          end
          default: begin
            err  = CheckEn;
            kind = ErrOrphan;
          end
        endcase
      end else if (CheckEn && len_q == MaxLen) begin
        err     = 1'b1;
        kind    = ErrOverflow;
        state_d = StIdle;
        len_d   = '0;
      end else if (ftype == FLIT_TAIL) begin
        state_d = StIdle;
        len_d   = '0;
        fin     = 1'b1;
        fin_len = len_sat;
      end else begin
        len_d = len_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      len_out_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      // ack follows req one cycle late: rises after accept, falls after req drops.
      ack_q   <= req;
      done_q  <= fin;
      if (fin) len_out_q <= fin_len;
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign len  = len_out_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && err) begin
      $display("packet_sink_mc id=%0d ch=%0d framing error: %s", ID, CH, kind.name());
    end
  end
`endif

endmodule

// File: rtl/packet_sink_mc.sv
// Multi-channel packet sink: per-channel receivers plus saturating flit/packet/error counters.
// err_count is live only when PACKET_SINK_CHECK_EN is defined.
module packet_sink_mc
  import noc_pkg::*;
#(
  parameter int unsigned ID        = 0,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned BUFF_BITS = 3,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               ch_req,
  input  logic [NUM_CH*SIZE-1:0]          ch_flit,
  output logic [NUM_CH-1:0]               ch_ack,
  output logic [NUM_CH-1:0]               pkt_done,
  output logic [NUM_CH*(BUFF_BITS+1)-1:0] pkt_len,
  output logic [CNT_BITS-1:0]             flit_count,
  output logic [CNT_BITS-1:0]             pkt_count,
  output logic [CNT_BITS-1:0]             err_count
);

  localparam int unsigned IncW = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0]   accept, fin, err;
  logic [CNT_BITS-1:0] flit_q, pkt_q, err_q;
  logic                unused_payload;

  // Payload bits are never inspected.
  assign unused_payload = ^ch_flit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sink_channel #(
      .ID       (ID),
      .CH       (i),
      .BUFF_BITS(BUFF_BITS)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .req   (ch_req[i]),
      .ftype (ch_flit[i*SIZE+SIZE-FLIT_TYPE_W +: FLIT_TYPE_W]),
      .ack   (ch_ack[i]),
      .done  (pkt_done[i]),
      .len   (pkt_len[i*(BUFF_BITS+1) +: BUFF_BITS+1]),
      .accept(accept[i]),
      .fin   (fin[i]),
      .err   (err[i])
    );
  end

  function automatic logic [IncW-1:0] popcnt(logic [NUM_CH-1:0] v);
    logic [IncW-1:0] r = '0;
    for (int k = 0; k < NUM_CH; k++) r = r + IncW'(v[k]);
    return r;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_add(logic [CNT_BITS-1:0] c, logic [IncW-1:0] inc);
    logic [CNT_BITS:0] s;
    s = {1'b0, c} + (CNT_BITS+1)'(inc);
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_q <= '0;
      pkt_q  <= '0;
    end else begin
      flit_q <= sat_add(flit_q, popcnt(accept));
      pkt_q  <= sat_add(pkt_q, popcnt(fin));
    end
  end

`ifdef PACKET_SINK_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= sat_add(err_q, popcnt(err));
  end
  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = ^err;
  assign err_q      = '0;
  assign err_count  = '0;
`endif

  assign flit_count = flit_q;
  assign pkt_count  = pkt_q;

endmodule

// File: doc/packet_sink_mc.md
# packet_sink_mc

Multi-channel packet sink: terminates up to NUM_CH router output channels at the edge of the NoC and consumes every flit offered on them. Each channel runs its own four-phase req/ack receiver and per-channel packet framing FSM. The block reports packet completions and keeps saturating flit, packet and error statistics. It replaces the single-channel sink in test fabrics and traffic benches, and needs no switch or buffer interface.

## Interface
- ID, 0: sink instance identifier (debug only)
- NUM_CH, 4: number of input channels, 1..8
- SIZE, 8: flit width in bits, >= 4
- BUFF_BITS, 3: max packet length is 2**BUFF_BITS flits
- CNT_BITS, 16: width of statistics counters
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ch_req  in  NUM_CH  per-channel request, level (four-phase)
- ch_flit  in  NUM_CH*SIZE  per-channel flit; channel i at [i*SIZE +: SIZE]
- ch_ack  out  NUM_CH  per-channel acknowledge
- pkt_done  out  NUM_CH  one-cycle pulse, packet completed on channel i
- pkt_len  out  NUM_CH*(BUFF_BITS+1)  length of the completed packet; valid with pkt_done[i]
- flit_count  out  CNT_BITS  total accepted flits, saturating
- pkt_count  out  CNT_BITS  total completed packets, saturating
- err_count  out  CNT_BITS  total framing errors, saturating

## Operation
- Flit type is flit[SIZE-1:SIZE-2]: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail). Payload bits are ignored.
- Handshake per channel:
  - A flit is accepted in a cycle where req=1 and ack=0; ack=1 from the next edge.
  - ack returns to 0 on the edge after req is seen at 0.
  - Flits offered while ack=1 are not accepted.
- Channel FSM: IDLE, IN_PKT.
  - IDLE + head: len=1, go to IN_PKT.
  - IDLE + single: pkt_done pulse with len=1, stay IDLE.
  - IN_PKT + body: len+1.
  - IN_PKT + tail: pkt_done pulse with len+1, go to IDLE.
- Framing errors (each adds 1 to err_count):
  - Body or tail in IDLE: flit dropped, stay IDLE.
  - Head or single in IN_PKT: abandon the current packet with no pkt_done, then process the flit as if the channel were IDLE.
  - Flit arriving when len already equals 2**BUFF_BITS: error, packet abandoned, go to IDLE. A tail that brings len to exactly 2**BUFF_BITS is legal.
- Every accepted flit counts in flit_count, including erroneous ones.
- Counter increments:
  - flit_count increases by the number of flits accepted that cycle (0..NUM_CH).
  - pkt_count increases by popcount(pkt_done) that cycle.
  - err_count increases by the number of channels flagging an error that cycle.
  - All three saturate at 2**CNT_BITS-1. They never wrap, and an add that would overshoot clamps to max.
- Channels are fully independent. Simultaneous events on all channels in one cycle are all honoured.

## Timing
- Reset (asserted low): all FSMs IDLE, len=0, ch_ack=0, pkt_done=0, pkt_len=0, all counters 0. Reset applied mid-packet discards the packet without counting it.
- Accept-to-ack latency: 1 cycle. pkt_done and pkt_len are registered and appear on the edge after tail acceptance. Counters update on that same edge.
- Minimum per-channel flit period is 2 cycles when the sender responds to ack within the same cycle.
- pkt_len holds its last value between pulses.

## Configuration
- PACKET_SINK_CHECK_EN defined:
  - Framing checks active and err_count live.
  - Simulation $display reports ID, channel and error kind for each error.
- PACKET_SINK_CHECK_EN undefined:
  - No checks. The flit type is still decoded: head starts a packet, tail or single ends one.
  - Body/tail in IDLE is silently dropped.
  - Head in IN_PKT restarts len without comment.
  - len saturates at 2**BUFF_BITS.
  - err_count is tied to 0.

## Structure
- Shared package noc_pkg: flit-type constants (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE), the flit-type bit positions, and the FSM state encoding.
- Sub-module sink_channel: one handshake and FSM per channel, generated NUM_CH times. It outputs ack, done, len and per-cycle accept/error strobes.
- The top level holds the popcount adders and the saturating counters.

## Test plan
- Reset, then a 3-flit packet (head, body, tail) on ch0 -> ch_ack toggles 3 times; pkt_done[0] pulses once with pkt_len=3; flit_count=3, pkt_count=1, err_count=0.
- Single flits on all 4 channels in the same cycle -> pkt_done=4'b1111 for one cycle; pkt_count +4; flit_count +4.
- Body on idle ch1, then head, head, tail -> err_count=2; exactly one pkt_done with pkt_len=2 (with CHECK_EN); flit_count=4.
- Packet of 9 flits with BUFF_BITS=3 -> the 9th flit raises the error, no pkt_done; an 8-flit packet afterwards completes with pkt_len=8.
- reset asserted after 2 of 4 flits on ch2 -> ack=0 and counters=0 immediately; a fresh 4-flit packet afterwards gives pkt_len=4.
- CNT_BITS=4 with 20 single-flit packets -> pkt_count and flit_count stick at 15.
